axil_master: RTL

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite master: FSM state encoding and write-response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite master: turns one cmd_* request into an AXI-Lite
// read or write and returns the outcome on the rsp_* handshake.
module axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic [ADDR_W-1:0] aximm_mst_awaddr,
  output logic              aximm_mst_awvalid,
  input  logic              aximm_mst_awready,
  output logic [DATA_W-1:0] aximm_mst_wdata,
  output logic              aximm_mst_wvalid,
  input  logic              aximm_mst_wready,
  input  logic [1:0]        aximm_mst_bresp,
  input  logic              aximm_mst_bvalid,
  output logic              aximm_mst_bready,
  output logic [ADDR_W-1:0] aximm_mst_araddr,
  output logic              aximm_mst_arvalid,
  input  logic              aximm_mst_arready,
  input  logic [DATA_W-1:0] aximm_mst_rdata,
  input  logic              aximm_mst_rvalid,
  output logic              aximm_mst_rready
);

  state_t              r_state,       w_state_nxt;
  logic                r_cmd_ready,   w_cmd_ready_nxt;
  logic                r_awvalid,     w_awvalid_nxt;
  logic                r_wvalid,      w_wvalid_nxt;
  logic                r_arvalid,     w_arvalid_nxt;
  logic                r_bready,      w_bready_nxt;
  logic                r_rready,      w_rready_nxt;
  logic                r_rsp_valid,   w_rsp_valid_nxt;
  logic                r_rsp_err,     w_rsp_err_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
  logic [ADDR_W-1:0]   r_addr,        w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata,       w_wdata_nxt;

  logic                w_cmd_fire;
  logic                w_aw_ok;
  logic                w_w_ok;

  assign w_cmd_fire = cmd_valid & r_cmd_ready;
  // A write channel is finished once its valid has dropped or handshakes this cycle.
  assign w_aw_ok    = !r_awvalid || aximm_mst_awready;
  assign w_w_ok     = !r_wvalid  || aximm_mst_wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = 1'b0;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_arvalid_nxt   = r_arvalid;
    w_bready_nxt    = r_bready;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;

    case (r_state)
      IDLE: begin
        w_cmd_ready_nxt = !w_cmd_fire;
        if (w_cmd_fire) begin
          w_addr_nxt  = cmd_addr;
          w_wdata_nxt = cmd_wdata;
          if (cmd_write) begin
            w_state_nxt   = WR_REQ;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = RD_ADDR;
            w_arvalid_nxt = 1'b1;
          end
        end
      end

      WR_REQ: begin
        if (r_awvalid && aximm_mst_awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && aximm_mst_wready)   w_wvalid_nxt  = 1'b0;
        if (w_aw_ok && w_w_ok) begin
          w_state_nxt  = WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end

      WR_RESP: begin
        if (aximm_mst_bvalid) begin
          w_state_nxt     = DONE;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = (aximm_mst_bresp != RESP_OKAY);
          w_rsp_rdata_nxt = '0;
        end
      end

      RD_ADDR: begin
        if (aximm_mst_arready) begin
          w_state_nxt   = RD_DATA;
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end

      RD_DATA: begin
        if (aximm_mst_rvalid) begin
          w_state_nxt     = DONE;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = aximm_mst_rdata;
        end
      end

      DONE: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready         = r_cmd_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_rdata         = r_rsp_rdata;
  assign rsp_err           = r_rsp_err;
  assign aximm_mst_awaddr  = r_addr;
  assign aximm_mst_awvalid = r_awvalid;
  assign aximm_mst_wdata   = r_wdata;
  assign aximm_mst_wvalid  = r_wvalid;
  assign aximm_mst_bready  = r_bready;
  assign aximm_mst_araddr  = r_addr;
  assign aximm_mst_arvalid = r_arvalid;
  assign aximm_mst_rready  = r_rready;

endmodule
